// File: rtl/scpu_pkg.sv
// scpu shared definitions: opcodes, instruction field positions,
// ALU operation enum, decode control bundle and immediate helpers.
package scpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_SLL  = 6'h07;
  localparam logic [5:0] OP_SRL  = 6'h08;
  localparam logic [5:0] OP_MUL  = 6'h09;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_LUI  = 6'h11;
  localparam logic [5:0] OP_ORI  = 6'h12;
  localparam logic [5:0] OP_LW   = 6'h18;
  localparam logic [5:0] OP_SW   = 6'h19;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_JMP  = 6'h22;
  localparam logic [5:0] OP_DUMP = 6'h3E;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_LSB = 11;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_MUL,
    ALU_PASSB
  } alu_op_e;

  localparam logic [1:0] IMM_SEXT = 2'd0;
  localparam logic [1:0] IMM_ZEXT = 2'd1;
  localparam logic [1:0] IMM_LUI  = 2'd2;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       use_imm;
    logic [1:0] imm_sel;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       beq;
    logic       bne;
    logic       jmp;
    logic       dump;
    logic       hlt;
    logic       rb_rd;
  } ctrl_t;

  function automatic logic [31:0] sext16(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/scpu_regfile.sv
// scpu register file: 32x32, two combinational read ports, one write
// port on clk. r0 reads zero and ignores writes. Sync active-high reset.
module scpu_regfile
  import scpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [4:0]       raddr_a,
  output logic [XLEN-1:0]  rdata_a,
  input  logic [4:0]       raddr_b,
  output logic [XLEN-1:0]  rdata_b
);

  logic [XLEN-1:0] m_registers [0:NREGS-1];
  logic [XLEN-1:0] regs_d      [0:NREGS-1];

  always_comb begin
    regs_d = m_registers;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_registers[i] <= '0;
    end else begin
      m_registers <= regs_d;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : m_registers[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : m_registers[raddr_b];

endmodule

// File: rtl/scpu.sv
// scpu: single-cycle 32-bit RISC CPU with inline ROM, RAM, decode, ALU.
// Ports: clk, reset (sync, active-high), halt (sticky), dumpState (pulse).
// Optional: define SCPU_MUL_EN to add the MUL (0x09) instruction.
module scpu
  import scpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_INIT  = "program.hex"
) (
  input  logic clk,
  input  logic reset,
  output logic halt,
  output logic dumpState
);

  localparam int unsigned IA = $clog2(IMEM_DEPTH);
  localparam int unsigned DA = $clog2(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [31:0] curPc;
  logic [31:0] pc_d;
  logic        halt_q, halt_d;
  logic        dump_q, dump_d;

  logic [31:0] iReg;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2, rb_addr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] simm, imm_ext;

  ctrl_t       ctrl;
  logic [31:0] rs1_val, rb_val;
  logic [31:0] op_b, alu_y;
  logic [31:0] dmem_rdata, wb_data;
  logic        rf_we, dmem_we, br_eq, br_take;

  assign iReg  = imem[curPc[IA-1:0]];
  assign op    = iReg[OP_MSB:OP_LSB];
  assign rd    = iReg[RD_LSB +: 5];
  assign rs1   = iReg[RS1_LSB +: 5];
  assign rs2   = iReg[RS2_LSB +: 5];
  assign imm16 = iReg[15:0];
  assign imm26 = iReg[25:0];
  assign simm  = sext16(imm16);

  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.imm_sel = IMM_SEXT;
    unique case (op)
      OP_ADD: ctrl.reg_we = 1'b1;
      OP_SUB: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.reg_we = 1'b1;
      end
      OP_AND: begin
        ctrl.alu_op = ALU_AND;
        ctrl.reg_we = 1'b1;
      end
      OP_OR: begin
        ctrl.alu_op = ALU_OR;
        ctrl.reg_we = 1'b1;
      end
      OP_XOR: begin
        ctrl.alu_op = ALU_XOR;
        ctrl.reg_we = 1'b1;
      end
      OP_SLT: begin
        ctrl.alu_op = ALU_SLT;
        ctrl.reg_we = 1'b1;
      end
      OP_SLL: begin
        ctrl.alu_op = ALU_SLL;
        ctrl.reg_we = 1'b1;
      end
      OP_SRL: begin
        ctrl.alu_op = ALU_SRL;
        ctrl.reg_we = 1'b1;
      end
`ifdef SCPU_MUL_EN
      OP_MUL: begin
        ctrl.alu_op = ALU_MUL;
        ctrl.reg_we = 1'b1;
      end
`endif
      OP_ADDI: begin
        ctrl.use_imm = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op  = ALU_PASSB;
        ctrl.use_imm = 1'b1;
        ctrl.imm_sel = IMM_LUI;
        ctrl.reg_we  = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_op  = ALU_OR;
        ctrl.use_imm = 1'b1;
        ctrl.imm_sel = IMM_ZEXT;
        ctrl.reg_we  = 1'b1;
      end
      OP_LW: begin
        ctrl.use_imm = 1'b1;
        ctrl.mem_re  = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      OP_SW: begin
        ctrl.use_imm = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.rb_rd   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.beq   = 1'b1;
        ctrl.rb_rd = 1'b1;
      end
      OP_BNE: begin
        ctrl.bne   = 1'b1;
        ctrl.rb_rd = 1'b1;
      end
      OP_JMP:  ctrl.jmp  = 1'b1;
      OP_DUMP: ctrl.dump = 1'b1;
      OP_HLT:  ctrl.hlt  = 1'b1;
      default: ;
    endcase
  end

  // Port B reads rd for stores and branches, rs2 for R-type.
  assign rb_addr = ctrl.rb_rd ? rd : rs2;

  scpu_regfile regs (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .rdata_a (rs1_val),
    .raddr_b (rb_addr),
    .rdata_b (rb_val)
  );

  always_comb begin
    imm_ext = simm;
    if (ctrl.imm_sel == IMM_ZEXT) imm_ext = {16'h0, imm16};
    if (ctrl.imm_sel == IMM_LUI)  imm_ext = {imm16, 16'h0};
  end

  assign op_b = ctrl.use_imm ? imm_ext : rb_val;

  always_comb begin
    alu_y = rs1_val + op_b;
    unique case (ctrl.alu_op)
      ALU_ADD:   alu_y = rs1_val + op_b;
      ALU_SUB:   alu_y = rs1_val - op_b;
      ALU_AND:   alu_y = rs1_val & op_b;
      ALU_OR:    alu_y = rs1_val | op_b;
      ALU_XOR:   alu_y = rs1_val ^ op_b;
      ALU_SLT:   alu_y = {31'h0, $signed(rs1_val) < $signed(op_b)};
      ALU_SLL:   alu_y = rs1_val << op_b[4:0];
      ALU_SRL:   alu_y = rs1_val >> op_b[4:0];
`ifdef SCPU_MUL_EN
      ALU_MUL:   alu_y = rs1_val * op_b;
`endif
      ALU_PASSB: alu_y = op_b;
      default:   alu_y = rs1_val + op_b;
    endcase
  end

  assign dmem_rdata = dmem[alu_y[DA-1:0]];
  assign wb_data    = ctrl.mem_re ? dmem_rdata : alu_y;

  // Halted or in reset: the current instruction must not commit.
  assign rf_we   = ctrl.reg_we & ~halt_q;
  assign dmem_we = ctrl.mem_we & ~halt_q & ~reset;

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[alu_y[DA-1:0]] <= rb_val;
  end

  assign br_eq   = (rb_val == rs1_val);
  assign br_take = (ctrl.beq & br_eq) | (ctrl.bne & ~br_eq);

  always_comb begin
    pc_d   = curPc + 32'd1;
    halt_d = halt_q;
    dump_d = 1'b0;
    if (halt_q) begin
      pc_d = curPc;
    end else if (ctrl.hlt) begin
      pc_d   = curPc;
      halt_d = 1'b1;
    end else if (ctrl.jmp) begin
      pc_d = {6'h0, imm26};
    end else if (br_take) begin
      pc_d = curPc + 32'd1 + simm;
    end else begin
      dump_d = ctrl.dump;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curPc  <= '0;
      halt_q <= 1'b0;
      dump_q <= 1'b0;
    end else begin
      curPc  <= pc_d;
      halt_q <= halt_d;
      dump_q <= dump_d;
    end
  end

  assign halt      = halt_q;
  assign dumpState = dump_q;

endmodule

// File: tb/tb_scpu.sv
// Directed self-checking bench for scpu.
// Programs are poked into the ROM; registers observed via regs.m_registers.
module tb_scpu;

  localparam logic [5:0] ADD  = 6'h01, SUB = 6'h02, AND_ = 6'h03;
  localparam logic [5:0] OR_  = 6'h04, XOR_ = 6'h05, SLT = 6'h06;
  localparam logic [5:0] SLL  = 6'h07, SRL = 6'h08, MUL = 6'h09;
  localparam logic [5:0] ADDI = 6'h10, LUI = 6'h11, ORI = 6'h12;
  localparam logic [5:0] LW   = 6'h18, SW  = 6'h19;
  localparam logic [5:0] BEQ  = 6'h20, BNE = 6'h21, JMP = 6'h22;
  localparam logic [5:0] DUMP = 6'h3E, HLT = 6'h3F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic halt, dumpState;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] prog [$];

  always #5 clk = ~clk;

  scpu #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256),
    .IMEM_INIT  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .halt      (halt),
    .dumpState (dumpState)
  );

  function automatic logic [31:0] er(logic [5:0] o, logic [4:0] d,
                                     logic [4:0] a, logic [4:0] b);
    return {o, d, a, b, 11'h0};
  endfunction

  function automatic logic [31:0] ei(logic [5:0] o, logic [4:0] d,
                                     logic [4:0] a, logic [15:0] imm);
    return {o, d, a, imm};
  endfunction

  function automatic logic [31:0] ej(logic [5:0] o, logic [25:0] t);
    return {o, t};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
  endtask

  task automatic reset_cpu();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_dump(output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (dumpState === 1'b1) begin
        seen = 1'b1;
        cyc  = c;
        break;
      end
    end
  endtask

  task automatic test_basic();
    bit seen;
    int cyc;
    prog.delete();
    prog.push_back(ei(ADDI, 1, 0, 16'd5));
    prog.push_back(ei(ADDI, 2, 0, 16'h41));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
    reset_cpu();
    wait_dump(seen, cyc);
    checks++;
    if (!seen || cyc !== 3) begin
      errors++;
      $display("FAIL basic_dump_cycle got seen=%0d cyc=%0d want cyc=3", seen, cyc);
    end
    checks++;
    if (dut.regs.m_registers[1] !== 32'd5) begin
      errors++;
      $display("FAIL basic_r1 got %h want %h", dut.regs.m_registers[1], 32'd5);
    end
    checks++;
    if (dut.regs.m_registers[2] !== 32'h41) begin
      errors++;
      $display("FAIL basic_r2 got %h want %h", dut.regs.m_registers[2], 32'h41);
    end
    checks++;
    if (dut.regs.m_registers[3] !== 32'h0) begin
      errors++;
      $display("FAIL basic_r3 got %h want 0", dut.regs.m_registers[3]);
    end
    @(negedge clk);
    checks++;
    if (dumpState !== 1'b0 || halt !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse_end got dump=%b halt=%b want 0 1", dumpState, halt);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.curPc !== 32'h0 || halt !== 1'b0 || dumpState !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got pc=%h halt=%b dump=%b want 0 0 0",
               dut.curPc, halt, dumpState);
    end
    checks++;
    if (dut.regs.m_registers[1] !== 32'h0 || dut.regs.m_registers[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got r1=%h r2=%h want 0 0",
               dut.regs.m_registers[1], dut.regs.m_registers[2]);
    end
    reset = 1'b0;
  endtask

  task automatic test_loop();
    bit seen;
    int cyc;
    prog.delete();
    prog.push_back(ei(ADDI, 1, 0, 16'd10));
    prog.push_back(ei(ADDI, 3, 0, 16'd0));
    prog.push_back(ei(ADDI, 3, 3, 16'd3));
    prog.push_back(ei(ADDI, 1, 1, 16'hFFFF));
    prog.push_back(ei(BNE, 1, 0, 16'hFFFD));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
    reset_cpu();
    wait_dump(seen, cyc);
    checks++;
    if (!seen || cyc !== 33) begin
      errors++;
      $display("FAIL loop_dump_cycle got seen=%0d cyc=%0d want 33", seen, cyc);
    end
    checks++;
    if (dut.regs.m_registers[3] !== 32'd30 || dut.regs.m_registers[1] !== 32'd0) begin
      errors++;
      $display("FAIL loop_regs got r3=%h r1=%h want 1e 0",
               dut.regs.m_registers[3], dut.regs.m_registers[1]);
    end
    @(negedge clk);
    checks++;
    if (halt !== 1'b1 || dut.curPc !== 32'd6) begin
      errors++;
      $display("FAIL loop_halt got halt=%b pc=%h want 1 6", halt, dut.curPc);
    end
  endtask

  task automatic test_mem();
    bit seen;
    int cyc;
    prog.delete();
    prog.push_back(ei(LUI, 2, 0, 16'hDEAD));
    prog.push_back(ei(ORI, 2, 2, 16'hBEEF));
    prog.push_back(ei(SW, 2, 0, 16'd4));
    prog.push_back(ei(LW, 3, 0, 16'd4));
    prog.push_back(ei(ADDI, 5, 0, 16'd6));
    prog.push_back(ei(LW, 4, 5, 16'hFFFE));
    prog.push_back(ei(ADDI, 6, 0, 16'h107));
    prog.push_back(ei(SW, 5, 6, 16'd0));
    prog.push_back(ei(LW, 7, 0, 16'd7));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
    reset_cpu();
    wait_dump(seen, cyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mem_dump got no pulse want pulse");
    end
    checks++;
    if (dut.regs.m_registers[2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_lui_ori got %h want deadbeef", dut.regs.m_registers[2]);
    end
    checks++;
    if (dut.regs.m_registers[3] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_sw_lw got %h want deadbeef", dut.regs.m_registers[3]);
    end
    checks++;
    if (dut.regs.m_registers[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_neg_off got %h want deadbeef", dut.regs.m_registers[4]);
    end
    checks++;
    if (dut.regs.m_registers[7] !== 32'd6) begin
      errors++;
      $display("FAIL mem_addr_wrap got %h want 6", dut.regs.m_registers[7]);
    end
  endtask

  task automatic test_arith();
    bit seen;
    int cyc;
    int          idx [13];
    logic [31:0] exp [13];
    prog.delete();
    prog.push_back(ei(ADDI, 0, 0, 16'd7));
    prog.push_back(ei(ADDI, 2, 0, 16'd1));
    prog.push_back(er(SUB, 1, 0, 2));
    prog.push_back(er(SLT, 3, 1, 0));
    prog.push_back(ei(ADDI, 4, 0, 16'hF0));
    prog.push_back(ei(ADDI, 5, 0, 16'h3C));
    prog.push_back(er(AND_, 6, 4, 5));
    prog.push_back(er(OR_, 7, 4, 5));
    prog.push_back(er(XOR_, 8, 4, 5));
    prog.push_back(ei(ADDI, 10, 0, 16'd4));
    prog.push_back(er(SLL, 9, 5, 10));
    prog.push_back(er(SRL, 11, 1, 10));
    prog.push_back(er(ADD, 12, 4, 5));
    prog.push_back(er(SLT, 13, 5, 4));
    prog.push_back(ei(ADDI, 15, 0, 16'h24));
    prog.push_back(er(SRL, 16, 4, 15));
    prog.push_back(er(ADD, 17, 1, 1));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
    reset_cpu();
    wait_dump(seen, cyc);
    checks++;
    if (!seen || cyc !== 18) begin
      errors++;
      $display("FAIL arith_dump_cycle got seen=%0d cyc=%0d want 18", seen, cyc);
    end
    idx = '{0, 1, 3, 6, 7, 8, 9, 11, 12, 13, 16, 17, 2};
    exp = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h30, 32'hFC, 32'hCC, 32'h3C0,
            32'h0FFFFFFF, 32'h12C, 32'h1, 32'hF, 32'hFFFFFFFE, 32'h1};
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (dut.regs.m_registers[idx[k]] !== exp[k]) begin
        errors++;
        $display("FAIL arith_r%0d got %h want %h",
                 idx[k], dut.regs.m_registers[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_branch();
    bit seen;
    int cyc;
    prog.delete();
    prog.push_back(ei(ADDI, 1, 0, 16'd2));
    prog.push_back(ei(BEQ, 1, 0, 16'd5));
    prog.push_back(ei(BNE, 1, 0, 16'd1));
    prog.push_back(ei(ADDI, 2, 0, 16'd99));
    prog.push_back(ej(JMP, 26'd6));
    prog.push_back(ei(ADDI, 2, 0, 16'd98));
    prog.push_back(ei(ADDI, 3, 0, 16'd1));
    prog.push_back(ei(BEQ, 3, 3, 16'd1));
    prog.push_back(ei(ADDI, 4, 0, 16'd77));
    prog.push_back(ei(BNE, 3, 3, 16'd1));
    prog.push_back(ei(ADDI, 5, 0, 16'd5));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
    reset_cpu();
    wait_dump(seen, cyc);
    checks++;
    if (!seen || cyc !== 9) begin
      errors++;
      $display("FAIL branch_dump_cycle got seen=%0d cyc=%0d want 9", seen, cyc);
    end
    checks++;
    if (dut.regs.m_registers[2] !== 32'h0 || dut.regs.m_registers[4] !== 32'h0) begin
      errors++;
      $display("FAIL branch_skipped got r2=%h r4=%h want 0 0",
               dut.regs.m_registers[2], dut.regs.m_registers[4]);
    end
    checks++;
    if (dut.regs.m_registers[3] !== 32'h1 || dut.regs.m_registers[5] !== 32'h5) begin
      errors++;
      $display("FAIL branch_taken_path got r3=%h r5=%h want 1 5",
               dut.regs.m_registers[3], dut.regs.m_registers[5]);
    end
  endtask

  task automatic test_halt();
    prog.delete();
    prog.push_back(ej(HLT, 26'h0));
    prog.push_back(ei(ADDI, 1, 0, 16'd9));
    load_prog();
    reset_cpu();
    @(negedge clk);
    checks++;
    if (halt !== 1'b1) begin
      errors++;
      $display("FAIL halt_rise got %b want 1", halt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (halt !== 1'b1 || dut.curPc !== 32'h0 || dut.regs.m_registers[1] !== 32'h0
        || dumpState !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen got halt=%b pc=%h r1=%h dump=%b want 1 0 0 0",
               halt, dut.curPc, dut.regs.m_registers[1], dumpState);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || dut.curPc !== 32'h0) begin
      errors++;
      $display("FAIL halt_reset got halt=%b pc=%h want 0 0", halt, dut.curPc);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (halt !== 1'b1 || dut.regs.m_registers[1] !== 32'h0) begin
      errors++;
      $display("FAIL halt_rerun got halt=%b r1=%h want 1 0",
               halt, dut.regs.m_registers[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] d;
    prog.delete();
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
    reset_cpu();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d[k] = dumpState;
    end
    checks++;
    if (d !== 3'b011 || halt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_dump got seq=%b halt=%b want 011 1", d, halt);
    end
  endtask

  task automatic test_mul();
    bit seen;
    int cyc;
    logic [31:0] e3, e5;
    prog.delete();
    prog.push_back(ei(ADDI, 1, 0, 16'd7));
    prog.push_back(ei(ADDI, 2, 0, 16'd6));
    prog.push_back(ei(ADDI, 3, 0, 16'd5));
    prog.push_back(ei(ADDI, 4, 0, 16'hFFFD));
    prog.push_back(ei(ADDI, 5, 0, 16'd1));
    prog.push_back(er(MUL, 3, 1, 2));
    prog.push_back(er(MUL, 5, 4, 2));
    prog.push_back(ej(DUMP, 26'h0));
    prog.push_back(ej(HLT, 26'h0));
    load_prog();
`ifdef SCPU_MUL_EN
    e3 = 32'd42;
    e5 = 32'hFFFFFFEE;
`else
    e3 = 32'd5;
    e5 = 32'd1;
`endif
    reset_cpu();
    wait_dump(seen, cyc);
    checks++;
    if (!seen || dut.regs.m_registers[3] !== e3) begin
      errors++;
      $display("FAIL mul_pos got seen=%0d r3=%h want %h",
               seen, dut.regs.m_registers[3], e3);
    end
    checks++;
    if (dut.regs.m_registers[5] !== e5) begin
      errors++;
      $display("FAIL mul_neg got %h want %h", dut.regs.m_registers[5], e5);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_reset();
    test_loop();
    test_mem();
    test_arith();
    test_branch();
    test_halt();
    test_back_to_back();
    test_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
